// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM-port signal bundle for sram_port_arbiter.
// The arbiter takes the slave modport; the environment (requesters plus SRAM) takes master.
interface sram_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;

    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_size, d_addr, d_wdata, sram_rdata,
        output i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_size, d_addr, d_wdata, sram_rdata,
        input  i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between instruction and data requesters,
// one access per cycle, with kseg0/kseg1 translation and byte-enable generation.
module sram_port_arbiter #(
    parameter int KSEG_XLATE             = 1,
    parameter int DATA_FIRST_AFTER_RESET = 1
) (
    input logic                 clk,
    input logic                 reset,
    sram_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;
    // Seeding last_grant with inst makes the first contended grant go to data.
    localparam logic LAST_GRANT_RST = (DATA_FIRST_AFTER_RESET != 0) ? GNT_I : GNT_D;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   grant_i, grant_d;

    function automatic logic [31:0] xlate_addr(input logic [31:0] vaddr);
        if ((KSEG_XLATE != 0) && (vaddr[31:30] == 2'b10))
            return {3'b000, vaddr[28:0]};
        return vaddr;
    endfunction

    function automatic logic [3:0] store_wen(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] wen;
        wen = 4'b0000;
        case (size)
            2'd0:    wen = 4'b0001 << off;
            2'd1:    if (!off[0]) wen = off[1] ? 4'b1100 : 4'b0011;
            2'd2:    if (off == 2'b00) wen = 4'b1111;
            default: wen = 4'b0000;
        endcase
        return wen;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_GRANT_RST;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (bus.i_req && bus.d_req) begin
            if (last_grant_q == GNT_D) grant_i = 1'b1;
            else                       grant_d = 1'b1;
        end else begin
            grant_i = bus.i_req;
            grant_d = bus.d_req;
        end

        state_d      = IDLE;
        last_grant_d = last_grant_q;
        if (grant_i) begin
            state_d      = RESP_I;
            last_grant_d = GNT_I;
        end else if (grant_d) begin
            state_d      = RESP_D;
            last_grant_d = GNT_D;
        end
    end

    always_comb begin
        bus.i_addr_ok  = 1'b0;
        bus.i_data_ok  = 1'b0;
        bus.i_rdata    = 32'h0;
        bus.d_addr_ok  = 1'b0;
        bus.d_data_ok  = 1'b0;
        bus.d_rdata    = 32'h0;
        bus.sram_en    = 1'b0;
        bus.sram_wen   = 4'b0000;
        bus.sram_addr  = 32'h0;
        bus.sram_wdata = 32'h0;
        // Reset silences everything, including a response still owed from the last cycle.
        if (!reset) begin
            case (state_q)
                RESP_I: begin
                    bus.i_data_ok = 1'b1;
                    bus.i_rdata   = bus.sram_rdata;
                end
                RESP_D: begin
                    bus.d_data_ok = 1'b1;
                    bus.d_rdata   = bus.sram_rdata;
                end
                default: ;
            endcase
            if (grant_i) begin
                bus.i_addr_ok = 1'b1;
                bus.sram_en   = 1'b1;
                bus.sram_addr = xlate_addr(bus.i_addr);
            end else if (grant_d) begin
                bus.d_addr_ok  = 1'b1;
                bus.sram_en    = 1'b1;
                bus.sram_addr  = xlate_addr(bus.d_addr);
                bus.sram_wen   = bus.d_wr ? store_wen(bus.d_size, bus.d_addr[1:0]) : 4'b0000;
                bus.sram_wdata = bus.d_wdata;
            end
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed vectors, a per-cycle reference model,
// and literal spot checks; a second instance covers KSEG_XLATE=0.
module tb_sram_port_arbiter;
    localparam logic [31:0] K = 32'hA5A5_5A5A;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    sram_port_arbiter_if b1 ();
    sram_port_arbiter_if b2 ();

    sram_port_arbiter #(.KSEG_XLATE(1), .DATA_FIRST_AFTER_RESET(1)) dut (
        .clk(clk), .reset(reset), .bus(b1.slave)
    );
    sram_port_arbiter #(.KSEG_XLATE(0), .DATA_FIRST_AFTER_RESET(1)) dut_nx (
        .clk(clk), .reset(reset), .bus(b2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM stand-in: read data is the accessed address scrambled by K, one cycle later.
    initial begin
        b1.sram_rdata = 32'h0;
        b2.sram_rdata = 32'h0;
    end
    always @(posedge clk) if (b1.sram_en) b1.sram_rdata <= b1.sram_addr ^ K;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] phys(input logic [31:0] va);
        int unsigned seg;
        seg = {28'd0, va[31:28]};
        if (seg >= 8 && seg <= 11)
            return va - ((seg >= 10) ? 32'hA000_0000 : 32'h8000_0000);
        return va;
    endfunction

    function automatic logic [3:0] exp_wen(input logic [1:0] size, input logic [31:0] a);
        if (size == 2'd0) begin
            case (a[1:0])
                2'd0: return 4'd1;
                2'd1: return 4'd2;
                2'd2: return 4'd4;
                default: return 4'd8;
            endcase
        end
        if (size == 2'd1) return (a[1:0] == 2'd0) ? 4'd3 : ((a[1:0] == 2'd2) ? 4'd12 : 4'd0);
        if (size == 2'd2) return (a[1:0] == 2'd0) ? 4'd15 : 4'd0;
        return 4'd0;
    endfunction

    // Reference model: pending response (0 none, 1 inst, 2 data) and who was served last.
    int          m_pend;
    logic [31:0] m_pend_data;
    bit          m_last_d;
    initial begin
        m_pend = 0; m_pend_data = 32'h0; m_last_d = 1'b0;
    end

    always @(negedge clk) begin
        logic [31:0] e_iaok, e_idok, e_daok, e_ddok, e_en, e_wen, e_addr, e_wdata;
        bit gi, gd;
        e_iaok = 0; e_idok = 0; e_daok = 0; e_ddok = 0;
        e_en = 0; e_wen = 0; e_addr = 0; e_wdata = 0;
        if (reset) begin
            chk("m_rst_i_rdata", b1.i_rdata, 32'h0);
            chk("m_rst_d_rdata", b1.d_rdata, 32'h0);
            m_pend = 0;
            m_last_d = 1'b0;
        end else begin
            if (m_pend == 1) e_idok = 1;
            if (m_pend == 2) e_ddok = 1;
            if (m_pend == 1) chk("m_i_rdata", b1.i_rdata, m_pend_data);
            if (m_pend == 2) chk("m_d_rdata", b1.d_rdata, m_pend_data);
            gi = b1.i_req && (!b1.d_req || m_last_d);
            gd = b1.d_req && !gi;
            if (gi) begin
                e_iaok = 1; e_en = 1; e_addr = phys(b1.i_addr);
                m_pend = 1; m_last_d = 1'b0;
            end else if (gd) begin
                e_daok = 1; e_en = 1; e_addr = phys(b1.d_addr);
                e_wen = b1.d_wr ? 32'(exp_wen(b1.d_size, b1.d_addr)) : 32'h0;
                e_wdata = b1.d_wdata;
                m_pend = 2; m_last_d = 1'b1;
            end else begin
                m_pend = 0;
            end
            m_pend_data = e_addr ^ K;
        end
        chk("m_i_addr_ok", 32'(b1.i_addr_ok), e_iaok);
        chk("m_i_data_ok", 32'(b1.i_data_ok), e_idok);
        chk("m_d_addr_ok", 32'(b1.d_addr_ok), e_daok);
        chk("m_d_data_ok", 32'(b1.d_data_ok), e_ddok);
        chk("m_sram_en", 32'(b1.sram_en), e_en);
        chk("m_sram_wen", 32'(b1.sram_wen), e_wen);
        chk("m_sram_addr", b1.sram_addr, e_addr);
        chk("m_sram_wdata", b1.sram_wdata, e_wdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic req, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        b1.d_req = req; b1.d_wr = wr; b1.d_size = size; b1.d_addr = addr; b1.d_wdata = wdata;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        b1.i_req = 1'b1; b1.i_addr = 32'hBFC0_0000;
        set_d(1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'h0);
        b2.i_req = 1'b0; b2.i_addr = 32'h0;
        b2.d_req = 1'b0; b2.d_wr = 1'b0; b2.d_size = 2'd0; b2.d_addr = 32'h0; b2.d_wdata = 32'h0;

        // Reset overrides requests that are already up
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_i_addr_ok", 32'(b1.i_addr_ok), 32'h0);
        chk("rst_d_addr_ok", 32'(b1.d_addr_ok), 32'h0);
        chk("rst_sram_en", 32'(b1.sram_en), 32'h0);
        chk("rst_sram_addr", b1.sram_addr, 32'h0);

        // Single kseg1 instruction fetch
        step(); reset = 1'b0; b1.d_req = 1'b0;
        @(negedge clk);
        chk("if_addr_ok", 32'(b1.i_addr_ok), 32'h1);
        chk("if_sram_addr", b1.sram_addr, 32'h1FC0_0000);
        chk("if_wen", 32'(b1.sram_wen), 32'h0);
        chk("if_first_data_ok", 32'(b1.i_data_ok), 32'h0);
        step(); b1.i_req = 1'b0;
        @(negedge clk);
        chk("if_data_ok", 32'(b1.i_data_ok), 32'h1);
        chk("if_rdata", b1.i_rdata, 32'hBA65_5A5A);

        // Contention: D,I,D,I
        step(); b1.i_req = 1'b1; b1.i_addr = 32'hBFC0_0004;
        set_d(1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'h0);
        @(negedge clk);
        chk("ct0_d_addr_ok", 32'(b1.d_addr_ok), 32'h1);
        chk("ct0_i_addr_ok", 32'(b1.i_addr_ok), 32'h0);
        chk("ct0_sram_addr", b1.sram_addr, 32'h0000_0010);
        step(); @(negedge clk);
        chk("ct1_i_addr_ok", 32'(b1.i_addr_ok), 32'h1);
        chk("ct1_d_data_ok", 32'(b1.d_data_ok), 32'h1);
        chk("ct1_d_rdata", b1.d_rdata, 32'hA5A5_5A4A);
        step(); @(negedge clk);
        chk("ct2_d_addr_ok", 32'(b1.d_addr_ok), 32'h1);
        chk("ct2_i_rdata", b1.i_rdata, 32'hBA65_5A5E);
        step(); @(negedge clk);
        chk("ct3_i_addr_ok", 32'(b1.i_addr_ok), 32'h1);

        // Stores: byte, half, word, then misaligned half
        step(); b1.i_req = 1'b0; set_d(1'b1, 1'b1, 2'd0, 32'h8000_0001, 32'h0000_AB00);
        @(negedge clk);
        chk("sb_wen", 32'(b1.sram_wen), 32'h2);
        chk("sb_addr", b1.sram_addr, 32'h0000_0001);
        chk("sb_wdata", b1.sram_wdata, 32'h0000_AB00);
        step(); set_d(1'b1, 1'b1, 2'd1, 32'h8000_0002, 32'hCDEF_0000);
        @(negedge clk);
        chk("sh_wen", 32'(b1.sram_wen), 32'hC);
        chk("sh_addr", b1.sram_addr, 32'h0000_0002);
        step(); set_d(1'b1, 1'b1, 2'd2, 32'h8000_0000, 32'h1234_5678);
        @(negedge clk);
        chk("sw_wen", 32'(b1.sram_wen), 32'hF);
        chk("sw_wdata", b1.sram_wdata, 32'h1234_5678);
        step(); set_d(1'b1, 1'b1, 2'd1, 32'h8000_0001, 32'h5555_5555);
        @(negedge clk);
        chk("mis_wen", 32'(b1.sram_wen), 32'h0);
        chk("mis_addr_ok", 32'(b1.d_addr_ok), 32'h1);
        step(); set_d(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("mis_data_ok", 32'(b1.d_data_ok), 32'h1);
        chk("idle_sram_en", 32'(b1.sram_en), 32'h0);
        chk("idle_sram_wdata", b1.sram_wdata, 32'h0);
        step(); set_d(1'b1, 1'b1, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        step(); set_d(1'b1, 1'b1, 2'd2, 32'h8000_0002, 32'hFFFF_FFFF);
        step(); set_d(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

        // Reset in the response cycle drops the pending data_ok
        step(); set_d(1'b1, 1'b0, 2'd2, 32'h8000_0020, 32'h0);
        @(negedge clk);
        chk("rr_addr_ok", 32'(b1.d_addr_ok), 32'h1);
        step(); set_d(1'b0, 1'b0, 2'd0, 32'h0, 32'h0); reset = 1'b1;
        @(negedge clk);
        chk("rr_d_data_ok", 32'(b1.d_data_ok), 32'h0);
        chk("rr_sram_en", 32'(b1.sram_en), 32'h0);
        step(); reset = 1'b0; b1.i_req = 1'b1; b1.i_addr = 32'hBFC0_0008;
        set_d(1'b1, 1'b0, 2'd2, 32'h8000_0030, 32'h0);
        @(negedge clk);
        chk("rr_first_d_grant", 32'(b1.d_addr_ok), 32'h1);
        chk("rr_no_d_data_ok", 32'(b1.d_data_ok), 32'h0);
        chk("rr_no_i_data_ok", 32'(b1.i_data_ok), 32'h0);

        // Untranslated segments
        step(); b1.i_addr = 32'h0040_0000; b1.d_req = 1'b0;
        @(negedge clk);
        chk("useg_addr", b1.sram_addr, 32'h0040_0000);
        step(); b1.i_addr = 32'hC000_1000;
        @(negedge clk);
        chk("kseg2_addr", b1.sram_addr, 32'hC000_1000);

        // Mixed traffic, checked only by the model
        for (int n = 0; n < 40; n++) begin
            step();
            b1.i_req = ($urandom_range(0, 3) != 0);
            b1.i_addr = {$urandom_range(0, 15) == 0 ? 4'h0 : 4'(8 + $urandom_range(0, 7)),
                         26'($urandom), 2'b00};
            set_d(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  {4'($urandom_range(8, 11)), 28'($urandom)}, $urandom);
        end
        step(); b1.i_req = 1'b0; set_d(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

        // Translation disabled
        b2.i_req = 1'b1; b2.i_addr = 32'h9000_0040;
        @(negedge clk);
        chk("nx_kseg0_addr", b2.sram_addr, 32'h9000_0040);
        chk("nx_i_addr_ok", 32'(b2.i_addr_ok), 32'h1);
        step(); b2.i_req = 1'b0; b2.d_req = 1'b1; b2.d_addr = 32'h0040_0000;
        @(negedge clk);
        chk("nx_useg_addr", b2.sram_addr, 32'h0040_0000);
        chk("nx_i_data_ok", 32'(b2.i_data_ok), 32'h1);
        step(); b2.d_req = 1'b0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the instruction-side and data-side SRAM-like requesters of MyCore.
- Per-requester handshake: req/addr_ok/data_ok. At most one access is outstanding, and a new access can issue in the response cycle of the previous one, so throughput is 1 access/cycle.
- Applies kseg0/kseg1 virtual-to-physical translation and generates SRAM byte write enables from size and address.
- Sits between the bus converters and the external SRAM port.

Parameters:
- KSEG_XLATE, 1, when 1 map addr[31:28] 8/9/A/B -> 0/1/0/1; all other segments pass through. When 0, no translation.
- DATA_FIRST_AFTER_RESET, 1, when 1 the first contended grant after reset goes to the data side.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_req  in  1  instruction read request
- i_addr  in  32  instruction virtual address (word aligned)
- i_addr_ok  out  1  instruction request accepted this cycle
- i_data_ok  out  1  instruction read data valid
- i_rdata  out  32  instruction read data
- d_req  in  1  data request
- d_wr  in  1  1=store, 0=load
- d_size  in  2  0=byte, 1=half, 2=word
- d_addr  in  32  data virtual address
- d_wdata  in  32  store data, already lane-aligned by core
- d_addr_ok  out  1  data request accepted this cycle
- d_data_ok  out  1  data access complete / load data valid
- d_rdata  out  32  load data (full word)
- sram_en  out  1  SRAM access enable
- sram_wen  out  4  SRAM byte write enables
- sram_addr  out  32  physical address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid one cycle after sram_en

Behaviour:
- States: IDLE (nothing outstanding), RESP_I (inst access issued last cycle), RESP_D (data access issued last cycle). A register last_grant records the side most recently granted.
- Grant: evaluated combinationally in every state (IDLE, RESP_I and RESP_D).
  - Only one req high: grant it.
  - Both high: grant the side != last_grant.
  - Reset value of last_grant: inst if DATA_FIRST_AFTER_RESET=1, else data.
- Grant cycle:
  - The granted side's x_addr_ok=1.
  - sram_en=1 and sram_addr=translated address of that side.
  - Next state = RESP_I or RESP_D; last_grant updates.
  - No grant: sram_en=0 and next state = IDLE.
- Response cycle (RESP_x): x_data_ok=1 and x_rdata=sram_rdata, driven combinationally from sram_rdata, for exactly one cycle. A new grant can occur in the same cycle.
- Inst access: sram_wen=4'b0000 always.
- Data load: sram_wen=0.
- Data store, wen by d_size and d_addr[1:0]:
  - byte: 1<<addr[1:0].
  - half: addr[1]=0 -> 4'b0011, addr[1]=1 -> 4'b1100.
  - word: 4'b1111.
- Misaligned store (half with addr[0]=1, word with addr[1:0]!=0, or size=3): wen=0. The access is still accepted and completes with d_data_ok.
- sram_wdata = d_wdata when data is granted, else 0.
- Idle SRAM outputs: sram_en=0, wen=0, addr=0, wdata=0.
- Requesters must hold req/addr/size/wdata stable until addr_ok. The arbiter holds no request state of its own.
- Reset values: state=IDLE. All addr_ok, data_ok and rdata outputs = 0, and all sram_* outputs = 0.
- Reset while an access is outstanding: the pending data_ok is dropped. No data_ok appears in the cycle after reset deasserts.
- Reset has priority over any grant in the same cycle.
- The arbiter never drives x_data_ok for a side that was not granted in the previous cycle.

Test Plan:
- Reset, then i_req=1 with i_addr=0xBFC0_0000 -> cycle0: i_addr_ok=1, sram_en=1, sram_addr=0x1FC0_0000, wen=0. Cycle1: i_data_ok=1, i_rdata=sram_rdata.
- i_req and d_req both high continuously (load at 0x8000_0010) -> grants alternate D,I,D,I starting with D. One access per cycle; each data_ok lands one cycle after the matching addr_ok.
- Stores at 0x8000_0001 (byte), 0x8000_0002 (half) and 0x8000_0000 (word) -> wen 0010, 1100, 1111; sram_addr 0x0000_000x; sram_wdata=d_wdata.
- Misaligned half store at addr 0x...1 -> wen=0000, d_addr_ok=1, and d_data_ok=1 the next cycle.
- Data grant, then reset asserted in the response cycle -> d_data_ok=0 and all sram_* = 0. After release, first contended grant goes to the data side.
- KSEG_XLATE=0 with addr 0x9000_0040 -> sram_addr=0x9000_0040. Address 0x0040_0000 (useg) passes unchanged in both modes.
